// File: rtl/fpu_mul_pkg.sv
// Shared sizing and the stage-1 payload type for the shared FP32 multiplier arbiter.
package fpu_mul_pkg;

   localparam int SIZE_DATA = 32;
   localparam int NUM_REQ   = 4;
   localparam int SIZE_ID   = $clog2(NUM_REQ);

   typedef struct packed {
      logic [SIZE_DATA-1:0] a;
      logic [SIZE_DATA-1:0] b;
      logic [SIZE_ID-1:0]   id;
   } s1_payload_t;

endpackage

// File: rtl/fpu_mul.sv
// Combinational IEEE-754 single-precision multiply, round-to-nearest-even.
// Subnormal inputs and results are flushed to signed zero; every NaN becomes 7fc00000.
module fpu_mul (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_result
);

   logic        w_sign;
   logic [7:0]  w_exp_a;
   logic [7:0]  w_exp_b;
   logic [22:0] w_man_a;
   logic [22:0] w_man_b;
   logic        w_zero_a;
   logic        w_zero_b;
   logic        w_inf_a;
   logic        w_inf_b;
   logic        w_nan_a;
   logic        w_nan_b;
   logic [47:0] w_prod;
   logic        w_norm;
   logic [46:0] w_frac;
   logic        w_round_up;
   logic        w_carry;
   logic [22:0] w_man_r;
   logic [9:0]  w_exp_sum;
   logic [7:0]  w_exp_res;

   assign w_sign   = i_a[31] ^ i_b[31];
   assign w_exp_a  = i_a[30:23];
   assign w_exp_b  = i_b[30:23];
   assign w_man_a  = i_a[22:0];
   assign w_man_b  = i_b[22:0];
   assign w_zero_a = (w_exp_a == 8'd0);
   assign w_zero_b = (w_exp_b == 8'd0);
   assign w_inf_a  = (w_exp_a == 8'hff) && (w_man_a == 23'd0);
   assign w_inf_b  = (w_exp_b == 8'hff) && (w_man_b == 23'd0);
   assign w_nan_a  = (w_exp_a == 8'hff) && (w_man_a != 23'd0);
   assign w_nan_b  = (w_exp_b == 8'hff) && (w_man_b != 23'd0);

   // Product of two 1.x mantissas lies in [1,4); bit 47 selects the extra normalising shift.
   assign w_prod     = 48'({1'b1, w_man_a}) * 48'({1'b1, w_man_b});
   assign w_norm     = w_prod[47];
   assign w_frac     = w_norm ? w_prod[46:0] : {w_prod[45:0], 1'b0};
   assign w_round_up = w_frac[23] & ((|w_frac[22:0]) | w_frac[24]);
   assign {w_carry, w_man_r} = {1'b0, w_frac[46:24]} + 24'(w_round_up);
   assign w_exp_sum  = {2'b00, w_exp_a} + {2'b00, w_exp_b} + {9'd0, w_norm} + {9'd0, w_carry};
   assign w_exp_res  = w_exp_sum[7:0] - 8'd127;

   always_comb begin
      o_result = {w_sign, w_exp_res, w_man_r};
      if (w_nan_a || w_nan_b || (w_inf_a && w_zero_b) || (w_zero_a && w_inf_b)) begin
         o_result = 32'h7fc00000;
      end else if (w_inf_a || w_inf_b) begin
         o_result = {w_sign, 8'hff, 23'd0};
      end else if (w_zero_a || w_zero_b) begin
         o_result = {w_sign, 31'd0};
      end else if (w_exp_sum >= 10'd382) begin
         o_result = {w_sign, 8'hff, 23'd0};
      end else if (w_exp_sum <= 10'd127) begin
         o_result = {w_sign, 31'd0};
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after i_ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int SIZE_ID = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [SIZE_ID-1:0] i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [SIZE_ID-1:0] o_idx
);

   logic w_found;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_found && i_req[(int'(i_ptr) + i) % NUM_REQ]) begin
            w_found = 1'b1;
            o_grant[(int'(i_ptr) + i) % NUM_REQ] = 1'b1;
            o_idx = SIZE_ID'((int'(i_ptr) + i) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/fpu_mul_arbiter.sv
// Shares one fpu_mul among NUM_REQ requesters: round-robin grant, operand and product
// registers around the multiplier, one tagged response channel with backpressure.
module fpu_mul_arbiter
   import fpu_mul_pkg::s1_payload_t;
#(
   parameter int SIZE_DATA = fpu_mul_pkg::SIZE_DATA,
   parameter int NUM_REQ   = fpu_mul_pkg::NUM_REQ,
   parameter int SIZE_ID   = $clog2(NUM_REQ)
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic [NUM_REQ-1:0]             i_req_valid,
   output logic [NUM_REQ-1:0]             o_req_ready,
   input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_a,
   input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_b,
   output logic                           o_rsp_valid,
   output logic [SIZE_ID-1:0]             o_rsp_id,
   output logic [SIZE_DATA-1:0]           o_rsp_data,
   input  logic                           i_rsp_ready,
   output logic                           o_busy
);

   s1_payload_t          r_s1;
   logic                 r_s1_valid;
   logic                 r_s2_valid;
   logic [SIZE_ID-1:0]   r_s2_id;
   logic [SIZE_DATA-1:0] r_s2_data;
   logic [SIZE_ID-1:0]   r_rr_ptr;

   logic                 w_s2_free;
   logic                 w_s1_free;
   logic [NUM_REQ-1:0]   w_grant;
   logic [SIZE_ID-1:0]   w_idx;
   logic                 w_req_hs;
   logic [SIZE_DATA-1:0] w_product;

   assign w_s2_free = !r_s2_valid || i_rsp_ready;
   assign w_s1_free = !r_s1_valid || w_s2_free;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .SIZE_ID (SIZE_ID)
   ) u_rr_arbiter (
      .i_req   (i_req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx)
   );

   // Ready is masked by reset so nothing can look accepted while the pipeline is held clear.
   assign o_req_ready = (i_rst_n && w_s1_free) ? w_grant : '0;
   assign w_req_hs    = |(i_req_valid & o_req_ready);

   fpu_mul u_fpu_mul (
      .i_a      (r_s1.a),
      .i_b      (r_s1.b),
      .o_result (w_product)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1       <= '0;
         r_rr_ptr   <= '0;
      end else if (w_req_hs) begin
         r_s1_valid <= 1'b1;
         r_s1.a     <= i_req_a[int'(w_idx)*SIZE_DATA +: SIZE_DATA];
         r_s1.b     <= i_req_b[int'(w_idx)*SIZE_DATA +: SIZE_DATA];
         r_s1.id    <= w_idx;
         r_rr_ptr   <= (w_idx == SIZE_ID'(NUM_REQ-1)) ? '0 : w_idx + 1'b1;
      end else if (w_s2_free) begin
         r_s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_id    <= '0;
         r_s2_data  <= '0;
      end else if (r_s1_valid && w_s2_free) begin
         r_s2_valid <= 1'b1;
         r_s2_id    <= r_s1.id;
         r_s2_data  <= w_product;
      end else if (i_rsp_ready) begin
         r_s2_valid <= 1'b0;
      end
   end

   assign o_rsp_valid = r_s2_valid;
   assign o_rsp_id    = r_s2_id;
   assign o_rsp_data  = r_s2_data;
   assign o_busy      = r_s1_valid || r_s2_valid;

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Directed bench for fpu_mul_arbiter: accepted requests feed a scoreboard that a
// separate response monitor drains, checking tag, product, latency and stall stability.
module tb_fpu_mul_arbiter;

   logic         clk = 1'b0;
   logic         rstN = 1'b1;
   logic [3:0]   reqValid = '0;
   logic [3:0]   reqReady;
   logic [127:0] reqA = '0;
   logic [127:0] reqB = '0;
   logic         rspValid;
   logic [1:0]   rspId;
   logic [31:0]  rspData;
   logic         rspReady = 1'b1;
   logic         busy;

   typedef struct {
      int          id;
      logic [31:0] data;
      int          cyc;
      bit          lat;
   } exp_t;

   exp_t        sb[$];
   int          grantQ[$];
   logic [31:0] expData [4];
   bit          chkLat = 1'b1;
   int          cyc = 0;
   int          nAcc = 0;
   int          nChecks = 0;
   int          nErrors = 0;
   exp_t        accE;
   exp_t        rspE;
   bit          holdPrev = 1'b0;
   logic [1:0]  prevId;
   logic [31:0] prevData;

   fpu_mul_arbiter dut (
      .i_clk       (clk),
      .i_rst_n     (rstN),
      .i_req_valid (reqValid),
      .o_req_ready (reqReady),
      .i_req_a     (reqA),
      .i_req_b     (reqB),
      .o_rsp_valid (rspValid),
      .o_rsp_id    (rspId),
      .o_rsp_data  (rspData),
      .i_rsp_ready (rspReady),
      .o_busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      nChecks++;
      if (act !== req) begin
         nErrors++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic failNote(input string name);
      nChecks++;
      nErrors++;
      $display("[TB] FAIL %s: event occurred, required none", name);
   endtask

   task automatic applyStimulus(input int k, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] product);
      reqA[k*32 +: 32] = a;
      reqB[k*32 +: 32] = b;
      expData[k] = product;
   endtask

   // Record every request handshake and compare the granted index with the planned order.
   always @(negedge clk) begin
      if (rstN) begin
         for (int k = 0; k < 4; k++) begin
            if (reqValid[k] && reqReady[k]) begin
               nAcc++;
               accE.id = k;
               accE.data = expData[k];
               accE.cyc = cyc;
               accE.lat = chkLat;
               sb.push_back(accE);
               checkOutput("ready_onehot", 64'($countones(reqReady)), 64'd1);
               if (grantQ.size() == 0) failNote("unexpected_grant");
               else checkOutput("grant_order", 64'(k), 64'(grantQ.pop_front()));
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rstN) begin
         holdPrev = 1'b0;
      end else if (rspValid && rspReady) begin
         holdPrev = 1'b0;
         if (sb.size() == 0) begin
            failNote("unexpected_rsp");
         end else begin
            rspE = sb.pop_front();
            checkOutput("rsp_id", 64'(rspId), 64'(rspE.id));
            checkOutput("rsp_data", 64'(rspData), 64'(rspE.data));
            if (rspE.lat) checkOutput("rsp_latency", 64'(cyc - rspE.cyc), 64'd2);
         end
      end else if (rspValid) begin
         if (holdPrev) begin
            checkOutput("stall_id", 64'(rspId), 64'(prevId));
            checkOutput("stall_data", 64'(rspData), 64'(prevData));
         end
         holdPrev = 1'b1;
         prevId = rspId;
         prevData = rspData;
      end else begin
         holdPrev = 1'b0;
      end
   end

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_req_ready"}, 64'(reqReady), 64'd0);
      checkOutput({tag, "_rsp_valid"}, 64'(rspValid), 64'd0);
      checkOutput({tag, "_rsp_id"}, 64'(rspId), 64'd0);
      checkOutput({tag, "_rsp_data"}, 64'(rspData), 64'd0);
      checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   task automatic doReset();
      @(posedge clk);
      #1;
      rstN = 1'b0;
      reqValid = '0;
      sb.delete();
      grantQ.delete();
      #2;
      checkResetOutputs("reset");
      @(posedge clk);
      #1;
      rstN = 1'b1;
   endtask

   task automatic waitReady(input int k);
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!reqReady[k] && t < 20);
      checkOutput("wait_ready", 64'(reqReady[k]), 64'd1);
   endtask

   // Each requester drops its valid the cycle after it is accepted.
   task automatic runUntilIdle(input string name, input int expIter);
      logic [3:0] acc;
      int it = 0;
      while (reqValid != 0 && it < 20) begin
         @(negedge clk);
         acc = reqValid & reqReady;
         @(posedge clk);
         #1;
         reqValid = reqValid & ~acc;
         it++;
      end
      checkOutput({name, "_cycles"}, 64'(it), 64'(expIter));
      reqValid = '0;
   endtask

   task automatic drain();
      int t = 0;
      while ((sb.size() != 0 || rspValid) && t < 20) begin
         @(posedge clk);
         t++;
      end
      #1;
      checkOutput("drain_sb", 64'(sb.size()), 64'd0);
      checkOutput("drain_grants", 64'(grantQ.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int startAcc;

      doReset();

      applyStimulus(0, 32'h3f800000, 32'h403f5c29, 32'h403f5c29);
      grantQ.push_back(0);
      reqValid = 4'b0001;
      waitReady(0);
      @(posedge clk);
      #1;
      reqValid = '0;
      @(negedge clk);
      checkOutput("t1_busy_s1", 64'(busy), 64'd1);
      checkOutput("t1_rsp_early", 64'(rspValid), 64'd0);
      @(negedge clk);
      checkOutput("t1_busy_s2", 64'(busy), 64'd1);
      checkOutput("t1_rsp_valid", 64'(rspValid), 64'd1);
      @(negedge clk);
      checkOutput("t1_busy_idle", 64'(busy), 64'd0);
      drain();

      doReset();
      for (int k = 0; k < 4; k++) begin
         applyStimulus(k, 32'h40000000, 32'h40400000, 32'h40c00000);
         grantQ.push_back(k);
      end
      reqValid = 4'b1111;
      runUntilIdle("t2", 4);
      drain();

      applyStimulus(0, 32'h3fc00000, 32'h40000000, 32'h40400000);
      applyStimulus(2, 32'h3fc00000, 32'h40000000, 32'h40400000);
      for (int i = 0; i < 3; i++) begin
         grantQ.push_back(0);
         grantQ.push_back(2);
      end
      startAcc = nAcc;
      reqValid = 4'b0101;
      repeat (6) @(posedge clk);
      #1;
      reqValid = '0;
      checkOutput("t3_accepts", 64'(nAcc - startAcc), 64'd6);
      drain();

      chkLat = 1'b0;
      rspReady = 1'b0;
      applyStimulus(1, 32'h40800000, 32'h3f000000, 32'h40000000);
      grantQ.push_back(1);
      grantQ.push_back(1);
      startAcc = nAcc;
      reqValid = 4'b0010;
      waitReady(1);
      @(posedge clk);
      #1;
      applyStimulus(1, 32'h40400000, 32'h3f000000, 32'h3fc00000);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("bp_handshakes", 64'(nAcc - startAcc), 64'd2);
      @(negedge clk);
      checkOutput("bp_ready_low", 64'(reqReady), 64'd0);
      @(posedge clk);
      #1;
      reqValid = '0;
      rspReady = 1'b1;
      drain();
      chkLat = 1'b1;

      applyStimulus(3, 32'h7f800000, 32'h00000000, 32'h7fc00000);
      grantQ.push_back(3);
      reqValid = 4'b1000;
      runUntilIdle("t5_nan", 1);
      applyStimulus(3, 32'h3f800000, 32'h3f800000, 32'h3f800000);
      grantQ.push_back(3);
      reqValid = 4'b1000;
      runUntilIdle("t5_next", 1);
      drain();

      chkLat = 1'b0;
      rspReady = 1'b0;
      applyStimulus(2, 32'h40000000, 32'h40000000, 32'h40800000);
      grantQ.push_back(2);
      grantQ.push_back(2);
      reqValid = 4'b0100;
      waitReady(2);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("t6_busy_full", 64'(busy), 64'd1);
      #2;
      rstN = 1'b0;
      sb.delete();
      grantQ.delete();
      #1;
      checkResetOutputs("t6_async");
      reqValid = '0;
      rspReady = 1'b1;
      chkLat = 1'b1;
      @(posedge clk);
      #1;
      rstN = 1'b1;
      applyStimulus(0, 32'h40400000, 32'h40400000, 32'h41100000);
      applyStimulus(3, 32'h3f800000, 32'hc0000000, 32'hc0000000);
      grantQ.push_back(0);
      grantQ.push_back(3);
      reqValid = 4'b1001;
      runUntilIdle("t6_after", 2);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
